// File: rtl/float_add_pipe_if.sv
// Operand/result handshake bundle for float_add_pipe.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface float_add_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned Width = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] out;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/float_add_pipe.sv
// Pipelined IEEE-754-style adder/subtractor: capture, unpack/align, add, normalise, round/pack.
// One result per cycle; every stage holds while a presented result is not taken.
module float_add_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic             clk,
  input logic             rst_n,
  float_add_pipe_if.slave bus
);
  localparam int unsigned Width = 1 + EXP_W + MAN_W;
  localparam int unsigned MantW = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int unsigned LzcW  = $clog2(MantW + 1);

  localparam logic [Width-1:0] QNaN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

  typedef struct packed {
    logic             spec;
    logic [Width-1:0] spec_val;
    logic [3:0]       spec_flags;
    logic             sign;
    logic             zero_sign;
  } ctl_t;

  typedef struct packed {
    ctl_t             ctl;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [MantW-1:0] ma;
    logic [MantW-1:0] mb;
  } s1_t;

  typedef struct packed {
    ctl_t             ctl;
    logic [EXP_W-1:0] exp;
    logic [MantW:0]   sum;
  } s2_t;

  typedef struct packed {
    ctl_t             ctl;
    logic             zero;
    logic [EXP_W:0]   exp;
    logic [MantW-1:0] m;
  } s3_t;

  logic [4:0]       valid_q;
  logic [Width-1:0] a_q, b_q;
  logic             sub_q;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  s3_t              s3_d, s3_q;
  logic [Width-1:0] out_d, out_q;
  logic [3:0]       flags_d, flags_q;
  logic             adv;

  assign adv           = bus.out_ready | ~valid_q[4];
  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[4];
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;

  // Unpack / align
  logic               sa, sb, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_ge_b;
  logic [EXP_W-1:0]   ea, eb, ea_eff, eb_eff, diff;
  logic [MAN_W-1:0]   fa, fb;
  logic [MAN_W:0]     mant_l, mant_s;
  logic [LzcW-1:0]    shamt;
  logic [2*MantW-1:0] wide;

  assign sa     = a_q[Width-1];
  assign sb     = b_q[Width-1] ^ sub_q;
  assign ea     = a_q[Width-2 -: EXP_W];
  assign eb     = b_q[Width-2 -: EXP_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_snan = a_nan & ~fa[MAN_W-1];
  assign b_snan = b_nan & ~fb[MAN_W-1];
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_ge_b = a_q[Width-2:0] >= b_q[Width-2:0];
  assign ea_eff = (ea == '0) ? EXP_W'(1) : ea;
  assign eb_eff = (eb == '0) ? EXP_W'(1) : eb;
  assign mant_l = a_ge_b ? {|ea, fa} : {|eb, fb};
  assign mant_s = a_ge_b ? {|eb, fb} : {|ea, fa};
  assign diff   = a_ge_b ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
  assign shamt  = (32'(diff) >= MantW) ? LzcW'(MantW) : LzcW'(diff);
  // Lower half of the wide shift collects everything pushed past the sticky position.
  assign wide   = {mant_s, 3'b000, {MantW{1'b0}}} >> shamt;

  always_comb begin
    s1_d               = '0;
    s1_d.ctl.sign      = a_ge_b ? sa : sb;
    s1_d.ctl.zero_sign = sa & sb;
    s1_d.eff_sub       = sa ^ sb;
    s1_d.exp           = a_ge_b ? ea_eff : eb_eff;
    s1_d.ma            = {mant_l, 3'b000};
    s1_d.mb            = {wide[2*MantW-1:MantW+1], wide[MantW] | (|wide[MantW-1:0])};
    if (a_nan || b_nan) begin
      s1_d.ctl.spec       = 1'b1;
      s1_d.ctl.spec_val   = QNaN;
      s1_d.ctl.spec_flags = {a_snan | b_snan, 3'b000};
    end else if (a_inf && b_inf && (sa != sb)) begin
      s1_d.ctl.spec       = 1'b1;
      s1_d.ctl.spec_val   = QNaN;
      s1_d.ctl.spec_flags = 4'b1000;
    end else if (a_inf) begin
      s1_d.ctl.spec     = 1'b1;
      s1_d.ctl.spec_val = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_d.ctl.spec     = 1'b1;
      s1_d.ctl.spec_val = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // Add; operands are ordered so the difference never goes negative
  always_comb begin
    s2_d.ctl = s1_q.ctl;
    s2_d.exp = s1_q.exp;
    s2_d.sum = s1_q.eff_sub ? ({1'b0, s1_q.ma} - {1'b0, s1_q.mb})
                            : ({1'b0, s1_q.ma} + {1'b0, s1_q.mb});
  end

  // Normalise
  function automatic logic [LzcW-1:0] lzc(input logic [MantW-1:0] v);
    lzc = LzcW'(MantW);
    for (int i = 0; i < int'(MantW); i++) begin
      if (v[i]) lzc = LzcW'(int'(MantW) - 1 - i);
    end
  endfunction

  logic [LzcW-1:0]  lz;
  logic [EXP_W-1:0] exp_room, norm_sh;

  assign lz       = lzc(s2_q.sum[MantW-1:0]);
  assign exp_room = s2_q.exp - EXP_W'(1);
  // Stopping at exponent 1 leaves the hidden bit clear, which packs as a subnormal.
  assign norm_sh  = (32'(lz) > 32'(exp_room)) ? exp_room : EXP_W'(lz);

  always_comb begin
    s3_d.ctl  = s2_q.ctl;
    s3_d.zero = ~(|s2_q.sum);
    if (s2_q.sum[MantW]) begin
      s3_d.m   = {s2_q.sum[MantW:2], |s2_q.sum[1:0]};
      s3_d.exp = {1'b0, s2_q.exp} + (EXP_W + 1)'(1);
    end else begin
      s3_d.m   = s2_q.sum[MantW-1:0] << norm_sh;
      s3_d.exp = {1'b0, s2_q.exp} - {1'b0, norm_sh};
    end
  end

  // Round to nearest even and pack
  logic [MAN_W:0]   keep;
  logic [MAN_W+1:0] rounded;
  logic [MAN_W-1:0] frac_r;
  logic [EXP_W:0]   exp_r;
  logic             rnd_up, inexact;

  always_comb begin
    keep    = s3_q.m[MantW-1:3];
    inexact = |s3_q.m[2:0];
    rnd_up  = s3_q.m[2] & (s3_q.m[1] | s3_q.m[0] | keep[0]);
    rounded = {1'b0, keep} + (MAN_W + 2)'(rnd_up);
    frac_r  = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    if (rounded[MAN_W+1]) begin
      exp_r = s3_q.exp + (EXP_W + 1)'(1);
    end else if (rounded[MAN_W]) begin
      exp_r = s3_q.exp;
    end else begin
      exp_r = '0;
    end
    out_d   = {s3_q.ctl.sign, exp_r[EXP_W-1:0], frac_r};
    flags_d = {2'b00, (exp_r == '0) & inexact, inexact};
    if (exp_r >= {1'b0, {EXP_W{1'b1}}}) begin
      out_d   = {s3_q.ctl.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end
    if (s3_q.zero) begin
      out_d   = {s3_q.ctl.zero_sign, {(Width - 1){1'b0}}};
      flags_d = 4'b0000;
    end
    if (s3_q.ctl.spec) begin
      out_d   = s3_q.ctl.spec_val;
      flags_d = s3_q.ctl.spec_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      out_q   <= '0;
      flags_q <= '0;
    end else if (adv) begin
      valid_q <= {valid_q[3:0], bus.in_valid};
      a_q     <= bus.a;
      b_q     <= bus.b;
      sub_q   <= bus.sub;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_float_add_pipe.sv
// Bench for float_add_pipe (binary32): directed table, streaming with stalls, random ops
// scored against an exact-integer reference, and a mid-stream reset.
module tb_float_add_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  float_add_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();
  float_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] out;
    logic [3:0]  flags;
  } vec_t;

  vec_t        vecs[$];
  logic [35:0] exp_q[$];
  logic [31:0] op_a[$], op_b[$];
  logic        op_sub[$];
  bit          sb_en = 1'b0;
  int          n_out = 0;
  logic        held = 1'b0;
  logic [35:0] held_val = '0;

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %09h want %09h", name, got, want);
    end
  endtask

  // Exact reference: operands become integers in units of 2^-149, summed, then rounded.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub);
    logic         sa, sb, s, up;
    logic [7:0]   ea, eb;
    logic [22:0]  fa, fb;
    logic [299:0] ma, mb, m, kept, rem, half;
    int           p, sh;
    sa = a[31]; sb = b[31] ^ sub;
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0))
      return {((ea == 8'hFF && fa != 0 && !fa[22]) || (eb == 8'hFF && fb != 0 && !fb[22])),
              3'b000, 32'h7FC00000};
    if (ea == 8'hFF && eb == 8'hFF && sa != sb) return {4'b1000, 32'h7FC00000};
    if (ea == 8'hFF) return {4'b0000, sa, 31'h7F800000};
    if (eb == 8'hFF) return {4'b0000, sb, 31'h7F800000};
    ma = (ea == 0) ? 300'(fa) : (300'({1'b1, fa}) << (int'(ea) - 1));
    mb = (eb == 0) ? 300'(fb) : (300'({1'b1, fb}) << (int'(eb) - 1));
    if (sa == sb) begin m = ma + mb; s = sa; end
    else if (ma >= mb) begin m = ma - mb; s = sa; end
    else begin m = mb - ma; s = sb; end
    if (m == 0) return {4'b0000, sa & sb, 31'h0};
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    if (p <= 23) return {4'b0000, s, m[30:0]};
    sh   = p - 23;
    kept = m >> sh;
    rem  = m & ((300'(1) << sh) - 300'(1));
    half = 300'(1) << (sh - 1);
    up   = (rem > half) || (rem == half && kept[0]);
    kept = kept + 300'(up);
    if (kept[24]) begin kept = kept >> 1; sh++; end
    if (sh + 1 >= 255) return {4'b0101, s, 31'h7F800000};
    return {3'b000, rem != 0, s, 8'(sh + 1), kept[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] ref_op);
    logic [31:0] r;
    int          e;
    r = $urandom;
    e = int'(ref_op[30:23]);
    case ($urandom_range(0, 9))
      4, 5: begin
        e = e + int'($urandom_range(0, 2)) - 1;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        r[30:23] = e[7:0];
      end
      6: r[30:23] = 8'h00;
      7: case ($urandom_range(0, 3))
        0: r = {r[31], 8'hFF, 23'h0};
        1: r = {r[31], 8'hFF, 1'b1, r[21:0]};
        2: r = {r[31], 8'hFF, 1'b0, r[21:0] | 22'h1};
        default: r = {r[31], 31'h0};
      endcase
      8: r[30:23] = 8'hFE - 8'($urandom_range(0, 1));
      9: begin
        e = e - int'($urandom_range(20, 30));
        if (e < 0) e = 0;
        r[30:23] = e[7:0];
      end
      default: ;
    endcase
    return r;
  endfunction

  // Scoreboard and hold checker, sampled mid-cycle while inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (held && bus.out_valid) check("hold", {bus.flags, bus.out}, held_val);
      held     = bus.out_valid && !bus.out_ready;
      held_val = {bus.flags, bus.out};
      if (sb_en) begin
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.sub));
        if (bus.out_valid && bus.out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected output: got %09h want none", {bus.flags, bus.out});
          end else begin
            check("stream", {bus.flags, bus.out}, exp_q.pop_front());
          end
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  function automatic void add(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic sub, input logic [31:0] out, input logic [3:0] flags);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.sub = sub; v.out = out; v.flags = flags;
    vecs.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v);
    int lat;
    bus.a = v.a; bus.b = v.b; bus.sub = v.sub; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, " latency"}, 36'(lat), 36'd4);
    check(v.name, {bus.flags, bus.out}, {v.flags, v.out});
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input int n, input bit rnd_ready, input int stall_from);
    int sent = 0;
    int cyc  = 0;
    bit took;
    bus.in_valid = 1'b0;
    while (sent < n && cyc < 50 * n) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (took) sent++;
      if (!bus.in_valid || took) begin
        if (sent < n && (!rnd_ready || $urandom_range(0, 3) != 0)) begin
          bus.a = op_a.pop_front(); bus.b = op_b.pop_front(); bus.sub = op_sub.pop_front();
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      else bus.out_ready = !(cyc >= stall_from && cyc < stall_from + 3);
    end
    bus.in_valid = 1'b0;
    check("stream sent", 36'(sent), 36'(n));
  endtask

  task automatic drain();
    int k = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", 36'(exp_q.size()), 36'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] prev;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 36'(bus.out_valid), 36'd0);
    check("reset out/flags", {bus.flags, bus.out}, 36'd0);
    rst_n = 1'b1;
    #1;
    check("reset in_ready", 36'(bus.in_ready), 36'd1);
    @(posedge clk); #1;

    add("one+one",     32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    add("one-one",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    add("-0+-0",       32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    add("-0++0",       32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
    add("tie even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    add("above tie",   32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
    add("tie odd",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    add("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    add("denorm add",  32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000);
    add("norm->sub",   32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000);
    add("cancel",      32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000);
    add("three-one",   32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    add("inf-inf",     32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    add("qnan",        32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    add("snan",        32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    add("inf-finite",  32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000);
    add("finite-inf",  32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
    foreach (vecs[i]) run_vec(vecs[i]);

    sb_en = 1'b1;
    // Eight back-to-back operations with a three-cycle consumer stall in the middle
    prev = 32'h3F800000;
    for (int i = 0; i < 8; i++) begin
      op_a.push_back(prev);
      op_b.push_back(rand_op(prev));
      op_sub.push_back(1'(i));
      prev = prev + 32'h00012345;
    end
    base = n_out;
    run_stream(8, 1'b0, 6);
    drain();
    check("stream8 count", 36'(n_out - base), 36'd8);

    for (int i = 0; i < 400; i++) begin
      prev = rand_op($urandom);
      op_a.push_back(prev);
      op_b.push_back(rand_op(prev));
      op_sub.push_back(1'($urandom_range(0, 1)));
    end
    base = n_out;
    run_stream(400, 1'b1, 0);
    drain();
    check("random count", 36'(n_out - base), 36'd400);

    // Reset while operations are in flight: nothing may emerge afterwards
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.a = 32'h40000000 + 32'(i); bus.b = 32'h3F800000; bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset out_valid", 36'(bus.out_valid), 36'd0);
    check("midreset out/flags", {bus.flags, bus.out}, 36'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post-reset idle", 36'(bus.out_valid), 36'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
